// File: rtl/ahb_lite_word_master.sv
// ahb_lite_word_master
// Queues single-word read/write commands in a small FIFO and issues them as
// pipelined NONSEQ word transfers on an AHB-lite bus. Every accepted command
// produces exactly one response, returned in command order. A two-cycle ERROR
// response cancels any overlapped address phase, and that entry is re-issued.
module ahb_lite_word_master #(
  parameter int FIFO_DEPTH = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int WA_W  = ADDR_W - 2;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_DATA = 3'd2,
    ST_DATA      = 3'd3,
    ST_ERR2      = 3'd4
  } state_t;

  // Command storage: word address only, byte offset is dropped on entry
  logic [WA_W-1:0]   r_fifo_waddr [FIFO_DEPTH];
  logic              r_fifo_write [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifo_wdata [FIFO_DEPTH];
  logic [CNT_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_rd_ptr;

  state_t            r_state;
  logic [ADDR_W-1:0] r_haddr;
  logic [1:0]        r_htrans;
  logic              r_hwrite;
  logic [DATA_W-1:0] r_hwdata;
  logic [DATA_W-1:0] r_ap_wdata;   // write data of the entry in address phase
  logic              r_dp_write;   // direction of the entry in data phase
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;

  logic [CNT_W-1:0]  w_count;
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic [PTR_W-1:0]  w_head_idx;
  logic [PTR_W-1:0]  w_next_idx;
  logic [PTR_W-1:0]  w_wr_idx;
  logic              w_addr_pend;
  logic              w_data_pend;
  logic              w_err1;
  logic              w_issue;
  logic [WA_W-1:0]   w_iss_waddr;
  logic              w_iss_write;
  logic [DATA_W-1:0] w_iss_wdata;
  logic              w_unused;

  assign w_count    = r_wr_ptr - r_rd_ptr;
  assign w_empty    = (w_count == CNT_W'(0));
  assign w_full     = (w_count == CNT_W'(FIFO_DEPTH));
  assign w_push     = cmd_valid & ~w_full;
  assign w_head_idx = r_rd_ptr[PTR_W-1:0];
  assign w_next_idx = w_head_idx + PTR_W'(1);
  assign w_wr_idx   = r_wr_ptr[PTR_W-1:0];

  assign w_addr_pend = (r_state == ST_ADDR) | (r_state == ST_ADDR_DATA);
  assign w_data_pend = (r_state == ST_ADDR_DATA) | (r_state == ST_DATA) | (r_state == ST_ERR2);
  // First cycle of a two-cycle ERROR response on a live data phase
  assign w_err1      = ((r_state == ST_ADDR_DATA) | (r_state == ST_DATA)) & HRESP & ~HREADY;
  // The head leaves the FIFO only when its address phase is accepted
  assign w_pop       = w_addr_pend & HREADY;

  assign w_unused = ^cmd_addr[1:0];

  assign HADDR     = r_haddr;
  assign HTRANS    = r_htrans;
  assign HWRITE    = r_hwrite;
  assign HWDATA    = r_hwdata;
  assign HSIZE     = 3'b010;
  assign HBURST    = 3'b000;
  assign cmd_ready = ~w_full;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign busy      = ~w_empty | (r_state != ST_IDLE);

  // Store accepted commands; read data field is zeroed for reads
  always_ff @(posedge HCLK) begin
    if (w_push) begin
      r_fifo_waddr[w_wr_idx] <= cmd_addr[ADDR_W-1:2];
      r_fifo_write[w_wr_idx] <= cmd_write;
      r_fifo_wdata[w_wr_idx] <= cmd_write ? cmd_wdata : {DATA_W{1'b0}};
    end
  end

  // FIFO pointers with an extra wrap bit to tell full from empty
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wr_ptr <= CNT_W'(0);
      r_rd_ptr <= CNT_W'(0);
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + CNT_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + CNT_W'(1);
      end
    end
  end

  // Pick the entry for the next address phase. While an address phase is
  // completing, the one behind the head is next; with only the head stored,
  // a command being pushed on the same edge is forwarded so back-to-back
  // words keep the bus busy every cycle.
  always_comb begin
    w_issue     = 1'b0;
    w_iss_waddr = {WA_W{1'b0}};
    w_iss_write = 1'b0;
    w_iss_wdata = {DATA_W{1'b0}};
    if (w_addr_pend) begin
      if (w_count > CNT_W'(1)) begin
        w_issue     = 1'b1;
        w_iss_waddr = r_fifo_waddr[w_next_idx];
        w_iss_write = r_fifo_write[w_next_idx];
        w_iss_wdata = r_fifo_wdata[w_next_idx];
      end else if (w_push) begin
        w_issue     = 1'b1;
        w_iss_waddr = cmd_addr[ADDR_W-1:2];
        w_iss_write = cmd_write;
        w_iss_wdata = cmd_write ? cmd_wdata : {DATA_W{1'b0}};
      end else begin
        w_issue     = 1'b0;
      end
    end else begin
      if (!w_empty) begin
        w_issue     = 1'b1;
        w_iss_waddr = r_fifo_waddr[w_head_idx];
        w_iss_write = r_fifo_write[w_head_idx];
        w_iss_wdata = r_fifo_wdata[w_head_idx];
      end else begin
        w_issue     = 1'b0;
      end
    end
  end

  // Transfer sequencer: moves entries address phase -> data phase on HREADY
  // edges, drives all bus outputs and the response from registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= ST_IDLE;
      r_haddr     <= {ADDR_W{1'b0}};
      r_htrans    <= TR_IDLE;
      r_hwrite    <= 1'b0;
      r_hwdata    <= {DATA_W{1'b0}};
      r_ap_wdata  <= {DATA_W{1'b0}};
      r_dp_write  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= {DATA_W{1'b0}};
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (HREADY) begin
        if (w_data_pend) begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= HRESP;
          r_rsp_rdata <= (HRESP | r_dp_write) ? {DATA_W{1'b0}} : HRDATA;
        end
        if (w_addr_pend) begin
          r_dp_write <= r_hwrite;
          r_hwdata   <= r_ap_wdata;
        end
        if (w_issue) begin
          r_htrans   <= TR_NONSEQ;
          r_haddr    <= {w_iss_waddr, 2'b00};
          r_hwrite   <= w_iss_write;
          r_ap_wdata <= w_iss_wdata;
          r_state    <= w_addr_pend ? ST_ADDR_DATA : ST_ADDR;
        end else begin
          r_htrans   <= TR_IDLE;
          r_state    <= w_addr_pend ? ST_DATA : ST_IDLE;
        end
      end else if (w_err1) begin
        // Drop the overlapped address phase; its entry is still the FIFO head
        r_htrans <= TR_IDLE;
        r_state  <= ST_ERR2;
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_word_master.sv
// Bench for ahb_lite_word_master: an AHB-lite slave model with configurable
// wait states and address-decoded ERROR, a command-order reference model that
// predicts every response at acceptance time, and a monitor that pops the
// prediction queue on each rsp_valid pulse and checks bus-hold rules.
module tb_ahb_lite_word_master;

  logic        HCLK;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t        exp_q[$];
  rsp_t        mon_e;
  logic [31:0] m_mem [16];

  ahb_lite_word_master #(.FIFO_DEPTH(2), .ADDR_W(32), .DATA_W(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] init_val(int i);
    return (i == 0) ? 32'hDEAD_BEEF : (32'h5A5A_0000 + 32'(i));
  endfunction

  function automatic void model_init();
    for (int i = 0; i < 16; i++) m_mem[i] = init_val(i);
  endfunction

  // Reference model: word addressed by bits [5:2], bit 12 selects the error region
  function automatic void model_accept(logic wr, logic [31:0] addr, logic [31:0] wd);
    rsp_t r;
    int   idx;
    idx     = int'(addr[5:2]);
    r.err   = addr[12];
    r.rdata = 32'h0;
    if (wr) begin
      if (!addr[12]) m_mem[idx] = wd;
    end else if (!addr[12]) begin
      r.rdata = m_mem[idx];
    end
    exp_q.push_back(r);
  endfunction

  // ---------------- AHB-lite slave model ----------------
  int          s_fixed_wait = 0;   // -1 selects random 0..2 wait states
  logic [31:0] s_mem [16];
  logic        s_active;
  logic        s_write;
  logic        s_err;
  logic [3:0]  s_idx;
  int          s_left;

  function automatic int pick_wait();
    return (s_fixed_wait >= 0) ? s_fixed_wait : int'($urandom_range(0, 2));
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      s_active <= 1'b0;
      s_write  <= 1'b0;
      s_err    <= 1'b0;
      s_idx    <= 4'h0;
      s_left   <= 0;
      for (int i = 0; i < 16; i++) s_mem[i] <= init_val(i);
    end else if (HREADY) begin
      if (s_active && s_write && !s_err) s_mem[s_idx] <= HWDATA;
      if (HTRANS == 2'b10) begin
        s_active <= 1'b1;
        s_write  <= HWRITE;
        s_idx    <= HADDR[5:2];
        s_err    <= HADDR[12];
        s_left   <= pick_wait() + (HADDR[12] ? 1 : 0);
      end else begin
        s_active <= 1'b0;
      end
    end else begin
      s_left <= s_left - 1;
    end
  end

  assign HREADY = !s_active || (s_left == 0);
  assign HRESP  = s_active && s_err && (s_left <= 1);
  assign HRDATA = (s_active && !s_write && !s_err) ? s_mem[s_idx] : 32'hBAD0_BAD0;

  // ---------------- Monitor: scoreboard and bus rules ----------------
  logic        mon_started = 1'b0;
  logic [1:0]  last_htrans;
  logic [31:0] last_haddr;
  logic        last_hwrite;
  logic [31:0] last_hwdata;
  logic        last_hready;
  logic        last_hresp;

  always @(negedge HCLK) begin
    if (!HRESETn) begin
      mon_started <= 1'b0;
    end else begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: rsp_valid high with no outstanding command");
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, mon_e.rdata);
          chk("rsp_err", {31'h0, rsp_err}, {31'h0, mon_e.err});
        end
      end
      if (HTRANS == 2'b10) chk("haddr_align", {30'h0, HADDR[1:0]}, 32'h0);
      if (mon_started && !last_hready && last_hresp) begin
        chk("err_cancel_htrans", {30'h0, HTRANS}, 32'h0);
      end else if (mon_started && !last_hready) begin
        chk("hold_htrans", {30'h0, HTRANS}, {30'h0, last_htrans});
        chk("hold_haddr", HADDR, last_haddr);
        chk("hold_hwrite", {31'h0, HWRITE}, {31'h0, last_hwrite});
        chk("hold_hwdata", HWDATA, last_hwdata);
      end
      mon_started <= 1'b1;
    end
    last_htrans <= HTRANS;
    last_haddr  <= HADDR;
    last_hwrite <= HWRITE;
    last_hwdata <= HWDATA;
    last_hready <= HREADY;
    last_hresp  <= HRESP;
  end

  // ---------------- Stimulus helpers ----------------
  task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    bit done;
    done = 1'b0;
    @(negedge HCLK);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    for (int n = 0; n < 200 && !done; n++) begin
      if (cmd_ready) begin
        @(posedge HCLK);
        done = 1'b1;
        model_accept(wr, addr, wd);
      end else begin
        @(posedge HCLK);
        @(negedge HCLK);
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept: command at %h not accepted within 200 cycles", addr);
    end
  endtask

  task automatic wait_nonseq(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      if (HTRANS == 2'b10) ok = 1'b1;
      else @(negedge HCLK);
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    @(negedge HCLK);
    cmd_valid = 1'b0;
    for (int n = 0; n < 500 && !done; n++) begin
      if (exp_q.size() == 0 && !busy) done = 1'b1;
      else @(negedge HCLK);
    end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'h0);
    chk("drain_busy", {31'h0, busy}, 32'h0);
  endtask

  task automatic check_reset_vals();
    chk("rst_htrans", {30'h0, HTRANS}, 32'h0);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hwrite", {31'h0, HWRITE}, 32'h0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
  endtask

  // ---------------- Test sequence ----------------
  initial begin
    bit          ok;
    int          run;
    int          maxrun;
    int          cnt;
    bit          saw_full;
    logic [31:0] a0;
    logic [31:0] ra;

    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0;
    cmd_wdata = 32'h0;
    model_init();
    HRESETn = 1'b1;
    #1 HRESETn = 1'b0;
    repeat (3) @(negedge HCLK);
    check_reset_vals();
    HRESETn = 1'b1;

    // 1: single zero-wait write
    s_fixed_wait = 0;
    send_cmd(1'b1, 32'h1000_0004, 32'h0000_000F);
    @(negedge HCLK);
    cmd_valid = 1'b0;
    wait_nonseq(ok);
    chk("t1_nonseq_seen", {31'h0, ok}, 32'h1);
    chk("t1_hwrite", {31'h0, HWRITE}, 32'h1);
    chk("t1_haddr", HADDR, 32'h1000_0004);
    @(negedge HCLK);
    chk("t1_htrans_one_cycle", {30'h0, HTRANS}, 32'h0);
    chk("t1_hwdata", HWDATA, 32'h0000_000F);
    chk("t1_rsp_not_yet", {31'h0, rsp_valid}, 32'h0);
    @(negedge HCLK);
    chk("t1_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    drain();

    // 2: read with three wait states
    s_fixed_wait = 3;
    send_cmd(1'b0, 32'h1000_0000, 32'h0);
    @(negedge HCLK);
    cmd_valid = 1'b0;
    wait_nonseq(ok);
    chk("t2_nonseq_seen", {31'h0, ok}, 32'h1);
    a0 = HADDR;
    for (int k = 0; k < 3; k++) begin
      @(negedge HCLK);
      chk("t2_wait_hready", {31'h0, HREADY}, 32'h0);
      chk("t2_haddr_stable", HADDR, a0);
    end
    drain();

    // 3: four back-to-back commands, zero wait states
    s_fixed_wait = 0;
    maxrun   = 0;
    run      = 0;
    saw_full = 1'b0;
    fork
      begin
        send_cmd(1'b1, 32'h1000_0010, 32'h1111_0001);
        send_cmd(1'b1, 32'h1000_0014, 32'h2222_0002);
        send_cmd(1'b0, 32'h1000_0010, 32'h0);
        send_cmd(1'b0, 32'h1000_0014, 32'h0);
        @(negedge HCLK);
        cmd_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 25; k++) begin
          @(negedge HCLK);
          if (!cmd_ready) saw_full = 1'b1;
          if (HTRANS == 2'b10) run++;
          else run = 0;
          if (run > maxrun) maxrun = run;
        end
      end
    join
    chk("t3_nonseq_run", 32'(maxrun), 32'd4);
    chk("t3_saw_not_ready", {31'h0, saw_full}, 32'h1);
    drain();

    // 4: ERROR on the first of two pipelined reads
    s_fixed_wait = 0;
    cnt = 0;
    fork
      begin
        send_cmd(1'b0, 32'h1000_1008, 32'h0);
        send_cmd(1'b0, 32'h1000_000C, 32'h0);
        @(negedge HCLK);
        cmd_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 20; k++) begin
          @(negedge HCLK);
          if (HTRANS == 2'b10 && HADDR == 32'h1000_000C) cnt++;
        end
      end
    join
    chk("t4_reissue_count", 32'(cnt), 32'd2);
    drain();

    // 6: unaligned address is forced to a word boundary
    s_fixed_wait = 0;
    send_cmd(1'b0, 32'h1000_0007, 32'h0);
    @(negedge HCLK);
    cmd_valid = 1'b0;
    wait_nonseq(ok);
    chk("t6_nonseq_seen", {31'h0, ok}, 32'h1);
    chk("t6_haddr", HADDR, 32'h1000_0004);
    chk("t6_hsize", {29'h0, HSIZE}, 32'h2);
    chk("t6_hburst", {29'h0, HBURST}, 32'h0);
    drain();

    // Randomized traffic: random gaps, wait states, errors and offsets
    s_fixed_wait = -1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge HCLK);
        cmd_valid = 1'b0;
      end
      ra = 32'h1000_0000 | (($urandom_range(0, 7) == 0) ? 32'h1000 : 32'h0)
           | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      send_cmd(1'($urandom_range(0, 1)), ra, $urandom);
    end
    drain();

    // 5: reset during a data phase abandons the transfer
    s_fixed_wait = 5;
    send_cmd(1'b0, 32'h1000_0010, 32'h0);
    @(negedge HCLK);
    cmd_valid = 1'b0;
    wait_nonseq(ok);
    chk("t5_nonseq_seen", {31'h0, ok}, 32'h1);
    @(negedge HCLK);
    #2 HRESETn = 1'b0;
    #1 check_reset_vals();
    exp_q.delete();
    model_init();
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge HCLK);
      if (rsp_valid) cnt++;
    end
    chk("t5_no_rsp_after_reset", 32'(cnt), 32'h0);
    chk("t5_busy_after_reset", {31'h0, busy}, 32'h0);

    // Bus still usable after the reset
    s_fixed_wait = 0;
    send_cmd(1'b0, 32'h1000_0000, 32'h0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
